// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t with flush; head is read combinationally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop   = pop & (count != '0);
    assign do_push  = push & ((count < CW'(DEPTH)) | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch PC, enqueue/redirect/fault control and the {pc, instr} buffer toward decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fault
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fpc;
    logic          primed;
    logic          deq;
    logic          enq;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  new_entry;

    // Handshake: a pair transfers on a rising edge where out_valid and out_ready
    // are both high; out_pc/out_instr hold while out_valid is high and out_ready low.
    assign out_valid = (count != '0) & !fault;
    assign deq       = out_valid & out_ready;
    assign enq       = !fault & !redirect_valid & ((count < CW'(DEPTH)) | deq);
    assign new_entry = '{pc: fpc, instr: imem_instr};
    assign imem_pc   = fpc;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (enq),
        .push_data (new_entry),
        .pop       (deq),
        .pop_data  (head),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc    <= RESET_PC;
            fault  <= 1'b0;
            primed <= 1'b0;
        end else if (redirect_valid) begin
            fpc   <= {redirect_pc[31:2], 2'b00};
            fault <= (redirect_pc[1:0] != 2'b00);
        end else if (enq) begin
            fpc    <= fpc + INSTR_BYTES;
            primed <= 1'b1;
        end
    end

    // Empty outputs read zero straight out of reset, NOP once fetch has run.
    assign out_pc    = out_valid ? head.pc : 32'h0;
    assign out_instr = out_valid ? head.instr : (primed ? NOP_INSTR : 32'h0);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end. Owns the fetch PC, drives the instruction memory's word-addressed, zero-latency read port, and buffers fetched {pc, instr} pairs in a small FIFO. The decode stage consumes the buffered pairs through a valid/ready handshake. The execute stage redirects fetch on taken branches and jumps. This block sits between the instruction memory and decode in the pipelined core.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC loaded on reset; must be 4-byte aligned.
- `DEPTH`, default 2: FIFO entries, legal range 2..16.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `imem_pc` out 32: fetch address, driven directly from the fetch PC register.
- `imem_instr` in 32: instruction word at `imem_pc`, valid in the same cycle (combinational memory).
- `redirect_valid` in 1: load a new fetch PC this cycle.
- `redirect_pc` in 32: redirect target.
- `out_valid` out 1: FIFO head holds a valid pair.
- `out_ready` in 1: decode accepts the head this cycle.
- `out_pc` out 32: PC of the head entry.
- `out_instr` out 32: instruction of the head entry.
- `fault` out 1: sticky flag set by a misaligned redirect target.

## Operation
- State:
  - `fpc` (32 bits).
  - FIFO of DEPTH entries: rd/wr pointers and `count`, `count` width $clog2(DEPTH+1).
  - `fault` flag.
- Reset values:
  - `fpc` = RESET_PC, so `imem_pc` = RESET_PC.
  - `count` = 0, pointers = 0.
  - `out_valid` = 0, `out_pc` = 0, `out_instr` = 0, `fault` = 0.
- Dequeue: `deq` = `out_valid & out_ready`.
- Enqueue condition: `enq` = `!fault & !redirect_valid & (count < DEPTH | deq)`.
- When `enq` is true:
  - Write {fpc, imem_instr} at the write pointer.
  - `fpc` <= `fpc` + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0.
- When neither `enq` nor redirect: `fpc` holds and `imem_pc` stays stable.
- Redirect (`redirect_valid` = 1), highest priority:
  - FIFO flushes: `count` <= 0 and pointers reset, regardless of `deq`.
  - No enqueue that cycle.
  - `redirect_pc[1:0]` == 0: `fpc` <= `redirect_pc` and `fault` <= 0.
  - `redirect_pc[1:0]` != 0: `fault` <= 1 and `fpc` <= {redirect_pc[31:2], 2'b00}. Fetch stays stopped.
- Fault: while set, no enqueue and `out_valid` = 0. Only an aligned redirect or reset clears it.
- FIFO count updates:
  - `enq & deq`: `count` unchanged.
  - `enq` only: `count` + 1.
  - `deq` only: `count` - 1.
- Output stability: `out_pc` and `out_instr` are the head entry. They stay stable while `out_valid & !out_ready`.
- `out_valid` = (`count` != 0).
- Reset mid-operation: asserting `rst_n` low immediately clears the FIFO and `fault`, and loads RESET_PC. No partial entry survives.

## Timing
- Fetch latency: a pair enqueued at edge N is visible on the outputs from cycle N+1.
- After reset release: first edge enqueues RESET_PC; `out_valid` = 1 in the following cycle.
- Redirect latency: redirect asserted in cycle R → `out_valid` = 0 in R+1 → first target instruction valid in R+2.
- Throughput: one instruction per cycle sustained when `out_ready` is held high, including when the FIFO is full.
- Backpressure: with `out_ready` = 0, the FIFO fills to DEPTH in DEPTH cycles. `fpc` then freezes at the next unfetched address.
- No combinational path from `out_ready` or `redirect_*` to `imem_pc`.

## Structure
- `fetch_pkg` holds:
  - `fetch_entry_t` (packed struct {pc[31:0], instr[31:0]}).
  - `INSTR_BYTES` = 4.
  - `NOP_INSTR` = 32'h0000_0013, the value driven on `out_instr` when empty, for waveform readability.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`, DEPTH parameter, with push/pop/flush/count. It is reusable for the future decode skid buffer.
- Top level contains the PC register, enqueue logic and fault logic.

## Test plan
- Reset then `out_ready` = 1 for 6 cycles → out_pc sequence 0x0, 0x4, 0x8, 0xC, 0x10. `out_instr` matches the memory image; one instruction per cycle.
- `out_ready` = 0 for 5 cycles → `count` saturates at 2 and `imem_pc` = 0x8 frozen. Head stays at pc 0x0. Releasing `out_ready` yields 0x0, 0x4, 0x8 with no duplicate or gap.
- Redirect to 0x100 while the FIFO is full and `out_ready` = 1 → `out_valid` = 0 next cycle, then out_pc = 0x100, 0x104. The old entries never appear.
- Redirect to 0x102 → `fault` = 1 and `out_valid` stays 0 for 10 cycles. A subsequent redirect to 0x200 clears `fault`, and out_pc = 0x200 two cycles later.
- RESET_PC = 32'hFFFF_FFF8 → out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
- `rst_n` pulsed low mid-stream at pc 0x40 → outputs cleared immediately, `fault` = 0, and fetch restarts at RESET_PC.
